id_ex_stage: RTL

ID/EX pipeline stage of the 5-stage MIPS core. It registers the decoded instruction from the ID stage into the EX stage. Its inputs are the register-file read data, the 32-bit sign-extended immediate from `sign_extend`, the register fields and the main-control bits. It also contains the load-use hazard detector: it raises `hazard_stall` to freeze PC and IF/ID, and inserts a bubble into EX. Branch resolution uses `flush` to squash the instruction entering EX.

---
 rtl/id_ex_stage.sv | 119 +++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with load-use hazard detection
// Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_branch,
  input  logic [1:0]        id_alu_op,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic              ex_branch,
  output logic [1:0]        ex_alu_op,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic uses_rt;
  logic load_use;
  logic bubble;

  // Stores and branches read rt as a source; so do R-types (alu_src=0).
  assign uses_rt  = id_mem_write | ~id_alu_src | id_branch;
  assign load_use = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                    ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));
  assign hazard_stall = load_use & ~flush;
  assign bubble       = flush | hazard_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_pc4        <= '0;
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_dest       <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= 2'b00;
      stall_cnt     <= '0;
    end else begin
      // Data and field registers load unconditionally; bubbles only gate control.
      ex_pc4  <= id_pc4;
      ex_rd1  <= id_rd1;
      ex_rd2  <= id_rd2;
      ex_imm  <= id_imm;
      ex_rs   <= id_rs;
      ex_rt   <= id_rt;
      ex_dest <= id_reg_dst ? id_rd : id_rt;
      if (bubble) begin
        ex_valid      <= 1'b0;
        ex_reg_write  <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_alu_src    <= 1'b0;
        ex_reg_dst    <= 1'b0;
        ex_branch     <= 1'b0;
        ex_alu_op     <= 2'b00;
      end else begin
        ex_valid      <= id_valid;
        ex_reg_write  <= id_reg_write  & id_valid;
        ex_mem_read   <= id_mem_read   & id_valid;
        ex_mem_write  <= id_mem_write  & id_valid;
        ex_mem_to_reg <= id_mem_to_reg & id_valid;
        ex_alu_src    <= id_alu_src    & id_valid;
        ex_reg_dst    <= id_reg_dst    & id_valid;
        ex_branch     <= id_branch     & id_valid;
        ex_alu_op     <= id_alu_op & {2{id_valid}};
      end
      if (hazard_stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
